// File: rtl/cache_mem_arbiter.sv
// Two-client line arbiter: merges I-cache fills and D-cache fills/writebacks onto one memory port.
// One transaction in flight; memory-side outputs and client responses are all registered.
module cache_mem_arbiter #(
  parameter int unsigned ADDR_WIDTH  = 16,
  parameter int unsigned LINE_WIDTH  = 128,
  parameter int unsigned OFFSET_BITS = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_read,
  input  logic [ADDR_WIDTH-1:0] i_address,
  output logic [LINE_WIDTH-1:0] i_rdata,
  output logic                  i_resp,
  input  logic                  d_read,
  input  logic                  d_write,
  input  logic [ADDR_WIDTH-1:0] d_address,
  input  logic [LINE_WIDTH-1:0] d_wdata,
  output logic [LINE_WIDTH-1:0] d_rdata,
  output logic                  d_resp,
  output logic                  pmem_read,
  output logic                  pmem_write,
  output logic [ADDR_WIDTH-1:0] pmem_address,
  output logic [LINE_WIDTH-1:0] pmem_wdata,
  input  logic [LINE_WIDTH-1:0] pmem_rdata,
  input  logic                  pmem_resp
);

  typedef enum logic [2:0] {StIdle, StIRd, StDRd, StDWr, StResp} state_e;

  state_e                  state_q;
  logic                    last_grant_d_q;  // 0: I-cache was granted last, 1: D-cache
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic [LINE_WIDTH-1:0]   wdata_q;
  logic [LINE_WIDTH-1:0]   line_q;
  logic                    pmem_read_q;
  logic                    pmem_write_q;
  logic                    i_resp_q;
  logic                    d_resp_q;

  logic                    d_req;
  logic                    pick_d;
  logic [ADDR_WIDTH-1:0]   grant_addr;

  // On a conflict the side that did not win last time gets the port.
  always_comb begin
    d_req      = d_read | d_write;
    pick_d     = d_req & (~i_read | ~last_grant_d_q);
    grant_addr = pick_d ? d_address : i_address;
    grant_addr[OFFSET_BITS-1:0] = '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= StIdle;
      last_grant_d_q <= 1'b0;
      addr_q         <= '0;
      wdata_q        <= '0;
      line_q         <= '0;
      pmem_read_q    <= 1'b0;
      pmem_write_q   <= 1'b0;
      i_resp_q       <= 1'b0;
      d_resp_q       <= 1'b0;
    end else begin
      i_resp_q <= 1'b0;
      d_resp_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (i_read | d_req) begin
            addr_q         <= grant_addr;
            last_grant_d_q <= pick_d;
            // A simultaneous d_read/d_write is treated as a writeback.
            if (pick_d && d_write) begin
              wdata_q      <= d_wdata;
              pmem_write_q <= 1'b1;
              state_q      <= StDWr;
            end else begin
              pmem_read_q  <= 1'b1;
              state_q      <= pick_d ? StDRd : StIRd;
            end
          end
        end
        StIRd, StDRd, StDWr: begin
          if (pmem_resp) begin
            pmem_read_q  <= 1'b0;
            pmem_write_q <= 1'b0;
            if (state_q != StDWr) begin
              line_q <= pmem_rdata;
            end
            i_resp_q <= (state_q == StIRd);
            d_resp_q <= (state_q != StIRd);
            state_q  <= StResp;
          end
        end
        StResp: begin
          // The following idle cycle lets the served client drop its request.
          state_q <= StIdle;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign pmem_read    = pmem_read_q;
  assign pmem_write   = pmem_write_q;
  assign pmem_address = addr_q;
  assign pmem_wdata   = wdata_q;
  assign i_resp       = i_resp_q;
  assign d_resp       = d_resp_q;
  assign i_rdata      = line_q;
  assign d_rdata      = line_q;

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// Bench for cache_mem_arbiter: directed scenarios plus randomized traffic checked against a
// transaction-level model (round-robin grant rule, reference line memory).
module tb_cache_mem_arbiter;

  logic         clk;
  logic         rst_n;
  logic         i_read;
  logic [15:0]  i_address;
  logic [127:0] i_rdata;
  logic         i_resp;
  logic         d_read;
  logic         d_write;
  logic [15:0]  d_address;
  logic [127:0] d_wdata;
  logic [127:0] d_rdata;
  logic         d_resp;
  logic         pmem_read;
  logic         pmem_write;
  logic [15:0]  pmem_address;
  logic [127:0] pmem_wdata;
  logic [127:0] pmem_rdata;
  logic         pmem_resp;

  int checks = 0;
  int errors = 0;

  bit m_last_d;                      // model: last granted side, 1 = D
  logic [127:0] ref_mem [int];       // what memory should hold
  logic [127:0] bus_mem [int];       // what the DUT actually wrote

  cache_mem_arbiter dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_read       (i_read),
    .i_address    (i_address),
    .i_rdata      (i_rdata),
    .i_resp       (i_resp),
    .d_read       (d_read),
    .d_write      (d_write),
    .d_address    (d_address),
    .d_wdata      (d_wdata),
    .d_rdata      (d_rdata),
    .d_resp       (d_resp),
    .pmem_read    (pmem_read),
    .pmem_write   (pmem_write),
    .pmem_address (pmem_address),
    .pmem_wdata   (pmem_wdata),
    .pmem_rdata   (pmem_rdata),
    .pmem_resp    (pmem_resp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  function automatic logic [127:0] default_line(int idx);
    logic [15:0] w;
    w = 16'(idx) ^ 16'h5A3C;
    return {8{w}};
  endfunction

  function automatic logic [127:0] ref_line(int idx);
    if (ref_mem.exists(idx)) return ref_mem[idx];
    return default_line(idx);
  endfunction

  function automatic logic [127:0] bus_line(int idx);
    if (bus_mem.exists(idx)) return bus_mem[idx];
    return default_line(idx);
  endfunction

  // Grant rule: a lone requester wins; on conflict the side not granted last time wins.
  function automatic bit pick_d();
    bit dq;
    dq = d_read | d_write;
    if (i_read && dq) return !m_last_d;
    return dq;
  endfunction

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, " pmem_read"},    128'(pmem_read),    128'd0);
    chk({tag, " pmem_write"},   128'(pmem_write),   128'd0);
    chk({tag, " pmem_address"}, 128'(pmem_address), 128'd0);
    chk({tag, " pmem_wdata"},   pmem_wdata,         128'd0);
    chk({tag, " i_resp"},       128'(i_resp),       128'd0);
    chk({tag, " d_resp"},       128'(d_resp),       128'd0);
    chk({tag, " i_rdata"},      i_rdata,            128'd0);
    chk({tag, " d_rdata"},      d_rdata,            128'd0);
  endtask

  // Called at a negedge where the DUT is idle and the current requests will be sampled at the
  // next posedge. Serves one transaction with memory latency lat; returns at the resp cycle.
  task automatic txn(input string tag, input int lat, input bit mutate, input bit drop,
                     input bit spur);
    bit           g_d;
    bit           g_wr;
    logic [15:0]  ea;
    logic [127:0] ew;
    logic [127:0] er;
    g_d  = pick_d();
    g_wr = g_d && d_write;
    ea   = (g_d ? d_address : i_address) & 16'hFFF0;
    ew   = d_wdata;
    m_last_d = g_d;
    @(negedge clk);
    pmem_resp = 1'b0;
    for (int c = 0; c <= lat; c++) begin
      chk({tag, " pmem_read"},  128'(pmem_read),  128'(!g_wr));
      chk({tag, " pmem_write"}, 128'(pmem_write), 128'(g_wr));
      chk({tag, " pmem_address"}, 128'(pmem_address), 128'(ea));
      if (g_wr) chk({tag, " pmem_wdata"}, pmem_wdata, ew);
      chk({tag, " early resp"}, 128'({i_resp, d_resp}), 128'd0);
      if (mutate && c == 0) begin
        if (g_d) begin
          d_address = 16'($urandom);
          d_wdata   = rand128();
          d_read    = 1'b0;
          d_write   = 1'b0;
        end else begin
          i_address = 16'hFFFF;
          i_read    = 1'b0;
        end
      end
      if (c == lat) begin
        pmem_resp = 1'b1;
        if (g_wr) begin
          bus_mem[int'(pmem_address >> 4)] = pmem_wdata;
          pmem_rdata = rand128();
        end else begin
          pmem_rdata = bus_line(int'(pmem_address >> 4));
        end
      end else begin
        pmem_rdata = rand128();
      end
      @(negedge clk);
      pmem_resp = 1'b0;
    end
    er = ref_line(int'(ea >> 4));
    if (g_wr) ref_mem[int'(ea >> 4)] = ew;
    chk({tag, " resp side"}, 128'({i_resp, d_resp}), 128'({!g_d, g_d}));
    chk({tag, " strobes in resp"}, 128'({pmem_read, pmem_write}), 128'd0);
    if (!g_wr) chk({tag, " rdata"}, g_d ? d_rdata : i_rdata, er);
    if (drop) begin
      if (g_d) begin
        d_read  = 1'b0;
        d_write = 1'b0;
      end else begin
        i_read = 1'b0;
      end
    end
    pmem_resp  = spur;
    pmem_rdata = rand128();
  endtask

  // The cycle after a response: no strobe, no resp, regardless of pmem_resp.
  task automatic idle(input string tag, input bit spur);
    @(negedge clk);
    pmem_resp = 1'b0;
    chk({tag, " idle strobes"}, 128'({pmem_read, pmem_write}), 128'd0);
    chk({tag, " idle resp"},    128'({i_resp, d_resp}), 128'd0);
    pmem_resp  = spur;
    pmem_rdata = rand128();
  endtask

  initial begin
    rst_n      = 1'b0;
    i_read     = 1'b0;
    i_address  = '0;
    d_read     = 1'b0;
    d_write    = 1'b0;
    d_address  = '0;
    d_wdata    = '0;
    pmem_rdata = '0;
    pmem_resp  = 1'b0;
    m_last_d   = 1'b0;
    #1;
    chk_all_zero("reset");
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Lone I-cache read
    ref_mem[16'h123] = {16{8'hA5}};
    bus_mem[16'h123] = {16{8'hA5}};
    i_read    = 1'b1;
    i_address = 16'h1234;
    txn("lone_i", 3, 1'b0, 1'b1, 1'b0);
    idle("lone_i", 1'b0);

    // D-cache writeback
    d_write   = 1'b1;
    d_address = 16'h8F80;
    d_wdata   = {4{32'hDEAD_BEEF}};
    txn("d_wb", 2, 1'b0, 1'b1, 1'b0);
    idle("d_wb", 1'b0);

    // Held conflicting reads alternate
    i_read    = 1'b1;
    i_address = 16'h2468;
    d_read    = 1'b1;
    d_address = 16'h8F85;
    for (int n = 0; n < 4; n++) begin
      txn("conflict", n + 1, 1'b0, 1'b0, 1'b0);
      if (n == 3) begin
        i_read = 1'b0;
        d_read = 1'b0;
      end
      idle("conflict", 1'b0);
    end

    // Request dropped and address changed mid-transaction
    i_read    = 1'b1;
    i_address = 16'h4568;
    txn("drop_chg", 3, 1'b1, 1'b1, 1'b0);
    idle("drop_chg", 1'b0);
    idle("drop_chg2", 1'b0);

    // Reset in the middle of a writeback
    d_write   = 1'b1;
    d_address = 16'h7770;
    d_wdata   = rand128();
    @(negedge clk);
    chk("rst_mid pmem_write", 128'(pmem_write), 128'd1);
    #2 rst_n = 1'b0;
    #1;
    chk_all_zero("rst_mid");
    m_last_d  = 1'b0;
    d_write   = 1'b0;
    d_read    = 1'b1;
    d_address = 16'h7773;
    @(negedge clk);
    rst_n = 1'b1;
    txn("after_rst", 2, 1'b0, 1'b1, 1'b0);
    idle("after_rst", 1'b0);

    // Spurious pmem_resp in idle, then a dual read/write request
    idle("spur", 1'b1);
    idle("spur2", 1'b0);
    d_read    = 1'b1;
    d_write   = 1'b1;
    d_address = 16'h3C3F;
    d_wdata   = rand128();
    txn("dual", 1, 1'b0, 1'b1, 1'b1);
    idle("dual", 1'b0);
    txn_check_readback();

    // Randomized traffic
    for (int n = 0; n < 60; n++) begin
      if (!i_read && $urandom_range(0, 1) == 1) begin
        i_read    = 1'b1;
        i_address = 16'($urandom);
      end
      if (!d_read && !d_write && $urandom_range(0, 1) == 1) begin
        int kind;
        kind      = int'($urandom_range(0, 5));
        d_read    = (kind < 3) || (kind == 5);
        d_write   = (kind >= 3);
        d_address = 16'($urandom_range(0, 3)) << 4;
        d_address = d_address | (16'($urandom) & 16'hFF0F);
        d_wdata   = rand128();
      end
      if (!i_read && !d_read && !d_write) begin
        i_read    = 1'b1;
        i_address = 16'($urandom_range(0, 63));
      end
      txn("rand", int'($urandom_range(0, 5)), $urandom_range(0, 7) == 0, 1'b1,
          $urandom_range(0, 1) == 1);
      idle("rand", $urandom_range(0, 1) == 1);
    end

    i_read  = 1'b0;
    d_read  = 1'b0;
    d_write = 1'b0;
    idle("end", 1'b0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Reads back the line written by the dual request through the I side.
  task automatic txn_check_readback();
    i_read    = 1'b1;
    i_address = 16'h3C30;
    txn("readback", 0, 1'b0, 1'b1, 1'b0);
    idle("readback", 1'b0);
  endtask

endmodule
